// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode encodings, instruction field
// positions and FSM state encodings.
package fetch_sequencer_pkg;

  localparam int INSTR_W = 28;
  localparam int OPC_W   = 4;
  localparam int OPC_MSB = 27;
  localparam int OPC_LSB = 24;
  localparam int DST_MSB = 23;
  localparam int DST_LSB = 16;
  localparam int SR1_MSB = 15;
  localparam int SR1_LSB = 8;
  localparam int SR0_MSB = 7;
  localparam int SR0_LSB = 0;
  localparam int IMM_MSB = 23;
  localparam int IMM_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP     = 4'h0,
    OP_LED     = 4'h1,
    OP_STO     = 4'h2,
    OP_ADD     = 4'h3,
    OP_SUB     = 4'h4,
    OP_MUL     = 4'h5,
    OP_IMUL    = 4'h6,
    OP_IMUL_16 = 4'h7,
    OP_BLE     = 4'h8,
    OP_JMP     = 4'h9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DELAY = 2'd3
  } state_e;

  // Opcodes that hand off to the multi-cycle execution unit
  function automatic logic isMultiCycle(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_IMUL) || (opc == OP_IMUL_16);
  endfunction

endpackage

// File: rtl/fetch_sequencer_delay_counter.sv
// Loadable down-counter used to stretch NOP immediates into stall cycles
// (only instantiated when FETCH_NOP_DELAY_EN is defined).
module delay_counter #(
  parameter int DLY_W = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic [DLY_W-1:0] iLoadValue,
  input  logic             iEnable,
  output logic             oLast
);

  logic [DLY_W-1:0] count_q;
  logic [DLY_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (iLoad) begin
      count_d = iLoadValue;
    end else if (iEnable && (count_q != '0)) begin
      count_d = count_q - DLY_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oLast = (count_q == DLY_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: FETCH -> ISSUE, stalling in WAIT for
// multi-cycle ops and, with FETCH_NOP_DELAY_EN defined, in DELAY for NOP immediates.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DLY_W    = 24
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iBranchTaken,
  input  logic               iExecBusy,
  output logic [ADDR_W-1:0]  oAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oIssue,
  output logic               oStalled
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   branchTarget;
  logic                takeBranch;

  // The NOP immediate occupies the DLY_W bits directly below the opcode
  assign opcode       = ir_q[DLY_W +: OPC_W];
  assign branchTarget = ADDR_W'(ir_q[DST_MSB:DST_LSB]);
  assign takeBranch   = (opcode == OP_JMP) || ((opcode == OP_BLE) && iBranchTaken);

`ifdef FETCH_NOP_DELAY_EN
  logic             dlyLoad;
  logic             dlyLast;
  logic [DLY_W-1:0] nopImm;

  assign nopImm = ir_q[DLY_W-1:0];

  delay_counter #(
    .DLY_W(DLY_W)
  ) u_delay_counter (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (dlyLoad),
    .iLoadValue (nopImm),
    .iEnable    (state_q == ST_DELAY),
    .oLast      (dlyLast)
  );
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    oIssue   = 1'b0;
    oStalled = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
    dlyLoad  = 1'b0;
`endif
    unique case (state_q)
      ST_FETCH: begin
        ir_d    = iInstruction;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        oIssue = 1'b1;
        pc_d   = takeBranch ? branchTarget : pc_q + ADDR_W'(1);
        if (isMultiCycle(opcode)) begin
          state_d = ST_WAIT;
`ifdef FETCH_NOP_DELAY_EN
        end else if ((opcode == OP_NOP) && (nopImm != '0)) begin
          state_d = ST_DELAY;
          dlyLoad = 1'b1;
`endif
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        oStalled = 1'b1;
        if (!iExecBusy) begin
          state_d = ST_FETCH;
        end
      end
`ifdef FETCH_NOP_DELAY_EN
      ST_DELAY: begin
        oStalled = 1'b1;
        if (dlyLast) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = ir_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; NOP-delay checks follow FETCH_NOP_DELAY_EN.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic        iExecBusy = 1'b0;
  logic [27:0] iInstruction;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic        oIssue;
  logic        oStalled;

  logic [27:0] rom [0:65535];
  int          vecCount = 0;
  int          missCount = 0;

  typedef struct {
    logic        br;
    logic        busy;
    logic [15:0] addr;
    logic        issue;
    logic        stall;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer #(
    .ADDR_W   (16),
    .RESET_PC (RST_PC),
    .DLY_W    (24)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iInstruction (iInstruction),
    .iBranchTaken (iBranchTaken),
    .iExecBusy    (iExecBusy),
    .oAddress     (oAddress),
    .oInstruction (oInstruction),
    .oIssue       (oIssue),
    .oStalled     (oStalled)
  );

  always #5 Clock = ~Clock;

  // Combinational ROM model
  assign iInstruction = rom[oAddress];

  task automatic addVec(input logic br, input logic busy, input logic [15:0] addr,
                        input logic issue, input logic stall);
    vec_t v;
    v.br = br; v.busy = busy; v.addr = addr; v.issue = issue; v.stall = stall;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic br, input logic busy);
    Reset        = rst;
    iBranchTaken = br;
    iExecBusy    = busy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expAddr,
                             input logic expIssue, input logic expStall);
    logic        ok;
    logic [27:0] expIr;
    expIr = expIssue ? rom[expAddr] : oInstruction;
    ok = (oAddress === expAddr) && (oIssue === expIssue) && (oStalled === expStall)
         && (oInstruction === expIr);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL %s: got addr=%h issue=%b stall=%b ir=%h, want addr=%h issue=%b stall=%b ir=%h",
               name, oAddress, oIssue, oStalled, oInstruction, expAddr, expIssue, expStall, expIr);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycle(input string name, input logic rst, input logic br, input logic busy,
                       input logic [15:0] addr, input logic issue, input logic stall);
    @(negedge Clock);
    checkOutput(name, addr, issue, stall);
    applyStimulus(rst, br, busy);
  endtask

  task automatic straightRun(input logic [15:0] startAddr, input int n);
    logic [15:0] a;
    a = startAddr;
    for (int i = 0; i < n; i++) begin
      cycle($sformatf("straightF_%h", a), 1'b1, 1'b0, 1'b0, a, 1'b0, 1'b0);
      cycle($sformatf("straightI_%h", a), 1'b1, 1'b0, 1'b0, a, 1'b1, 1'b0);
      a = a + 16'd1;
    end
  endtask

  initial begin
    int n;

    for (int a = 0; a < 65536; a++) begin
      rom[a] = {OP_STO, 8'h55, 8'h00, 8'(a)};
    end
    rom[4]  = {OP_IMUL_16, 8'h01, 8'h02, 8'h03};
    rom[9]  = {OP_BLE, 8'd8, 8'd1, 8'd2};
    rom[12] = {4'hF, 8'h03, 16'h0000};
    rom[14] = {OP_JMP, 8'd2, 16'h0000};

    // Cycle table starting at the ISSUE of RESET_PC
    addVec(0, 0, 16'hFFFE, 1, 0);
    addVec(0, 0, 16'hFFFF, 0, 0);
    addVec(0, 0, 16'hFFFF, 1, 0);
    for (int a = 0; a < 4; a++) begin
      addVec(0, 0, 16'(a), 0, 0);
      addVec(0, (a == 1), 16'(a), 1, 0);
    end
    addVec(0, 0, 16'd4, 0, 0);
    addVec(0, 0, 16'd4, 1, 0);
    for (int k = 0; k < 5; k++) addVec(0, 1, 16'd5, 0, 1);
    addVec(0, 0, 16'd5, 0, 1);
    for (int a = 5; a < 9; a++) begin
      addVec(0, 0, 16'(a), 0, 0);
      addVec(0, 0, 16'(a), 1, 0);
    end
    addVec(0, 0, 16'd9, 0, 0);
    addVec(1, 0, 16'd9, 1, 0);
    addVec(0, 0, 16'd8, 0, 0);
    addVec(0, 0, 16'd8, 1, 0);
    addVec(0, 0, 16'd9, 0, 0);
    addVec(0, 0, 16'd9, 1, 0);
    addVec(0, 0, 16'd10, 0, 0);
    addVec(1, 0, 16'd10, 1, 0);
    for (int a = 11; a < 14; a++) begin
      addVec(0, 0, 16'(a), 0, 0);
      addVec(0, 0, 16'(a), 1, 0);
    end
    addVec(0, 0, 16'd14, 0, 0);
    addVec(1, 0, 16'd14, 1, 0);
    addVec(0, 0, 16'd2, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkOutput("reset", RST_PC, 1'b0, 1'b0);
    checkValue("resetIr", 32'(oInstruction), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      checkOutput($sformatf("vec%0d", i), vecs[i].addr, vecs[i].issue, vecs[i].stall);
      applyStimulus(1'b1, vecs[i].br, vecs[i].busy);
    end

    rom[5] = {OP_NOP, 24'd0};
    rom[6] = {OP_NOP, 24'd4000};
    rom[7] = {OP_NOP, 24'd2000};

    // Reset while stalled in WAIT aborts the multiply
    cycle("rw2I", 1, 0, 0, 16'd2, 1, 0);
    cycle("rw3F", 1, 0, 0, 16'd3, 0, 0);
    cycle("rw3I", 1, 0, 0, 16'd3, 1, 0);
    cycle("rw4F", 1, 0, 0, 16'd4, 0, 0);
    cycle("rw4I", 1, 0, 0, 16'd4, 1, 0);
    cycle("rwWait1", 1, 0, 1, 16'd5, 0, 1);
    cycle("rwWait2", 0, 0, 1, 16'd5, 0, 1);
    cycle("rwAfter", 1, 0, 0, RST_PC, 0, 0);
    cycle("rwIssue", 1, 0, 0, RST_PC, 1, 0);
    straightRun(16'hFFFF, 5);

    // Busy already low in the first WAIT cycle: exactly one stall cycle
    cycle("w1_4F", 1, 0, 0, 16'd4, 0, 0);
    cycle("w1_4I", 1, 0, 0, 16'd4, 1, 0);
    cycle("w1Wait", 1, 0, 0, 16'd5, 0, 1);
    cycle("nop0F", 1, 0, 0, 16'd5, 0, 0);
    cycle("nop0I", 1, 0, 0, 16'd5, 1, 0);
    cycle("nop4000F", 1, 0, 0, 16'd6, 0, 0);
    cycle("nop4000I", 1, 0, 0, 16'd6, 1, 0);

`ifdef FETCH_NOP_DELAY_EN
    n = 0;
    while (n < 5000) begin
      @(negedge Clock);
      if (!(oStalled === 1'b1 && oIssue === 1'b0 && oAddress === 16'd7)) break;
      n++;
    end
    checkValue("nop4000Stall", 32'(n), 32'd4000);
    checkOutput("nop2000F", 16'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cycle("nop2000I", 1, 0, 0, 16'd7, 1, 0);
    repeat (766) @(negedge Clock);
    cycle("rdDelay1234", 0, 0, 0, 16'd8, 0, 1);
    cycle("rdAfter", 1, 0, 0, RST_PC, 0, 0);
    cycle("rdIssue", 1, 0, 0, RST_PC, 1, 0);
    cycle("rdNext", 1, 0, 0, 16'hFFFF, 0, 0);
`else
    n = 0;
    cycle("nopOff7F", 1, 0, 0, 16'd7, 0, 0);
    cycle("nopOff7I", 1, 0, 0, 16'd7, 1, 0);
    cycle("nopOff8F", 1, 0, 0, 16'd8, 0, 0);
    checkValue("nopOffNoDelay", 32'(n), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
